// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch unit that streams 32-bit instruction words from a single-outstanding
// request memory port into a small first-word-fall-through buffer feeding
// decode. A branch redirect flushes the buffer and re-steers fetch. A request
// already in flight when a branch arrives is drained, and its data dropped,
// before the new stream starts.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     instruction buffer entries (power of two, 2..16)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_req_o         read request to instruction memory
//   mem_addr_o        word-aligned read address (held until mem_ack_i)
//   mem_ack_i         single-cycle completion strobe, mem_data_i valid
//   mem_data_i        read data
//   instr_o, pc_o     head-of-buffer instruction and its fetch address
//   instr_valid_o     buffer is non-empty
//   instr_ready_i     decode accepts the head entry this cycle
//   branch_i          redirect request
//   branch_target_i   redirect address (bits [1:0] ignored)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'hE320_F000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [31:0]     stale_addr_reg, stale_addr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];

    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after_pop;
    logic [31:0]     branch_pc;

    assign branch_pc       = branch_target_i & ~32'h3;
    assign instr_valid_o   = (count_reg != '0);
    // A branch in the same cycle wins over decode's handshake.
    assign pop             = instr_valid_o && instr_ready_i && !branch_i;
    assign count_after_pop = count_reg - CW'(pop);

    // Head of the buffer is read combinationally so that data acked in
    // cycle N is visible to decode in cycle N+1.
    assign instr_o = instr_valid_o ? instr_mem[rd_ptr_reg] : NOP_INSTR;
    assign pc_o    = instr_valid_o ? pc_mem[rd_ptr_reg]    : 32'h0;

    assign mem_req_o = (state_reg != IDLE);

    always_comb begin
        mem_addr_o = 32'h0;
        case (state_reg)
            REQ:     mem_addr_o = fetch_pc_reg;
            DRAIN:   mem_addr_o = stale_addr_reg;
            default: mem_addr_o = 32'h0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        stale_addr_next = stale_addr_reg;
        push            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (branch_i) begin
                    fetch_pc_next = branch_pc;
                    state_next    = REQ;
                end else if (count_after_pop < DEPTH_C) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (branch_i) begin
                    fetch_pc_next = branch_pc;
                    if (mem_ack_i) begin
                        // Returning data belongs to the old stream; drop it.
                        state_next = REQ;
                    end else begin
                        // Keep presenting the in-flight address until it acks.
                        stale_addr_next = fetch_pc_reg;
                        state_next      = DRAIN;
                    end
                end else if (mem_ack_i) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    // Stop requesting once this push fills the buffer.
                    if ((count_after_pop + CW'(1)) < DEPTH_C)
                        state_next = REQ;
                    else
                        state_next = IDLE;
                end
            end
            DRAIN: begin
                if (branch_i)
                    fetch_pc_next = branch_pc;
                if (mem_ack_i)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (branch_i)
            count_next = '0;
        else
            count_next = count_after_pop + CW'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            stale_addr_reg <= 32'h0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            stale_addr_reg <= stale_addr_next;
            count_reg      <= count_next;
            if (branch_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Buffer storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem[wr_ptr_reg] <= mem_data_i;
            pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Cycle-by-cycle comparison of instruction_fetch against a transaction-level
// model: a queue for the instruction buffer, the current fetch address, and a
// record of whether a memory request is in flight and whether its data is
// still wanted. Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hE320_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        branch_i;
    logic [31:0] branch_target_i;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;          // next address the stream wants
    bit          m_busy;        // a memory request is in flight
    bit          m_stale;       // the in-flight request's data is unwanted
    logic [31:0] m_stale_addr;  // address of that unwanted request

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_addr();
        if (!m_busy)
            return 32'h0;
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc    = RESET_PC;
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_stale_addr = 32'h0;
    endtask

    // One clock: compare outputs, drive inputs, advance model at the edge.
    task automatic step(input bit r, input bit a, input bit b, input logic [31:0] t,
                        input bit rd, input logic [31:0] d);
        bit   valid;
        bit   a_eff;
        bit   pop;
        ent_t e;

        valid = (m_q.size() != 0);
        check_eq("mem_req",    {31'b0, mem_req_o},     {31'b0, m_busy});
        check_eq("mem_addr",   mem_addr_o,             model_addr());
        check_eq("instr_valid",{31'b0, instr_valid_o}, {31'b0, valid});
        check_eq("instr",      instr_o,                valid ? m_q[0].instr : NOP);
        check_eq("pc",         pc_o,                   valid ? m_q[0].pc : 32'h0);

        // The memory only acks something it has been asked for.
        a_eff           = a && m_busy;
        rst             = r;
        mem_ack_i       = a_eff;
        mem_data_i      = d;
        branch_i        = b;
        branch_target_i = t;
        instr_ready_i   = rd;

        @(posedge clk);

        if (r) begin
            model_reset();
        end else begin
            pop = valid && rd && !b;
            if (b) begin
                m_q.delete();
                if (m_busy && !a_eff && !m_stale) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end else if (!m_busy || a_eff) begin
                    m_busy  = 1'b1;
                    m_stale = 1'b0;
                end
                m_pc = t & ~32'h3;
            end else begin
                if (pop) begin
                    e = m_q.pop_front();
                    $display("pop pc=%h instr=%h", e.pc, e.instr);
                end
                if (m_busy && a_eff) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        e.instr = d;
                        e.pc    = m_pc;
                        m_q.push_back(e);
                        m_pc = m_pc + 32'd4;
                        if (m_q.size() >= DEPTH)
                            m_busy = 1'b0;
                    end
                end else if (!m_busy) begin
                    if (m_q.size() < DEPTH)
                        m_busy = 1'b1;
                end
            end
        end
        #1;
    endtask

    // Ack with data equal to the address being requested.
    task automatic ack_addr(input bit rd);
        step(1'b0, 1'b1, 1'b0, 32'h0, rd, model_addr());
    endtask

    initial begin
        logic [31:0] tgt;
        bit          rd_phase;

        rst = 1'b1; mem_ack_i = 1'b0; mem_data_i = '0;
        branch_i = 1'b0; branch_target_i = '0; instr_ready_i = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;

        // Reset state, including branch/ack under reset.
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);

        // Streaming with data = address, decode always ready.
        for (int i = 0; i < 8; i++) ack_addr(1'b1);

        // Decode stalls: buffer fills to DEPTH and requests stop.
        for (int i = 0; i < 10; i++) ack_addr(1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);

        // Branch while a request is outstanding without ack -> drain.
        for (int i = 0; i < 4 && !m_busy; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) ack_addr(1'b1);

        // Branch with coincident ack and pop while holding 3 entries.
        for (int i = 0; i < 12 && m_q.size() < 3; i++) ack_addr(1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 3; i++) ack_addr(1'b1);

        // Address wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) ack_addr(1'b1);

        // Reset in the middle of a stream with two buffered entries.
        for (int i = 0; i < 12 && m_q.size() < 2; i++) ack_addr(1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5);
        for (int i = 0; i < 4; i++) ack_addr(1'b1);

        // Randomized traffic.
        rd_phase = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) rd_phase = !rd_phase;
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                default: tgt = $urandom;
            endcase
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0,
                 tgt,
                 rd_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the number of instruction buffer entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_req_o  output  1  instruction memory read request.
REQ-006 mem_addr_o  output  32  word-aligned read address; valid while mem_req_o is high.
REQ-007 mem_ack_i  input  1  single-cycle completion strobe for the current request.
REQ-008 mem_data_i  input  32  read data; valid when mem_ack_i is high.
REQ-009 instr_o  output  32  instruction presented to decode.
REQ-010 pc_o  output  32  fetch address of instr_o.
REQ-011 instr_valid_o  output  1  instr_o and pc_o hold a buffered instruction.
REQ-012 instr_ready_i  input  1  decode accepts instr_o this cycle.
REQ-013 branch_i  input  1  redirect request; flushes the fetch stream.
REQ-014 branch_target_i  input  32  redirect address; bits [1:0] are ignored and forced to 0.

Function
REQ-015 The block SHALL hold a DEPTH-entry FIFO of {instruction, pc} pairs and an occupancy count of 0..DEPTH.
REQ-016 A pop SHALL occur only when instr_valid_o && instr_ready_i; instr_valid_o SHALL equal (count != 0).
REQ-017 With an empty FIFO, instr_o SHALL be 32'hE320F000 (AL NOP) and pc_o SHALL be 0.
REQ-018 The fetch state machine SHALL have states IDLE (mem_req_o=0), REQ (mem_req_o=1, mem_addr_o=fetch_pc) and DRAIN (mem_req_o=1, address of a stale request).
REQ-019 While mem_req_o is high, mem_addr_o SHALL stay stable until the cycle of mem_ack_i; only one request SHALL be outstanding.
REQ-020 IDLE->REQ when no branch and count minus this-cycle pop is less than DEPTH.
REQ-021 REQ with ack and no branch: push {mem_data_i, fetch_pc}; fetch_pc += 4 (wraps modulo 2^32); stay in REQ if the FIFO is not full after push and pop, else go to IDLE.
REQ-022 REQ with branch and no ack: flush FIFO, set fetch_pc = target, go to DRAIN while keeping the old mem_addr_o.
REQ-023 REQ with branch and ack in the same cycle: discard mem_data_i, flush FIFO, set fetch_pc = target, go to REQ.
REQ-024 DRAIN with ack: discard data, go to REQ, with mem_addr_o = fetch_pc on the next cycle.
REQ-025 DRAIN with branch: set fetch_pc to the newest target and stay in DRAIN; if ack coincides, discard it and go to REQ.
REQ-026 IDLE with branch: flush FIFO, set fetch_pc = target, and go to REQ on the next cycle.
REQ-027 Branch SHALL take priority over push and pop in the same cycle: no pop is counted and the FIFO is empty next cycle.
REQ-028 Simultaneous push and pop with count == DEPTH SHALL be legal and leave count unchanged.
REQ-029 Latency SHALL be: data acked in cycle N appears on instr_o with instr_valid_o=1 in cycle N+1 when the FIFO was empty.
REQ-030 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While rst is high: state=IDLE, mem_req_o=0, mem_addr_o=0, fetch_pc=RESET_PC, count=0, pointers=0, instr_valid_o=0, instr_o=32'hE320F000, pc_o=0.
REQ-032 rst SHALL override branch_i, mem_ack_i and pops in the same cycle; an ack arriving after reset for a pre-reset request is the memory's responsibility and is not discarded.
REQ-033 The first request after reset deassertion SHALL be issued to RESET_PC one cycle after rst falls.

Verification
REQ-034 Scenario: reset, ack every cycle with data = address, ready=1 -> instr_o/pc_o sequence 0,4,8,12 on consecutive cycles.
REQ-035 Scenario: ready=0, continuous acks -> exactly DEPTH (4) pushes, then mem_req_o=0, and count stays 4 until ready.
REQ-036 Scenario: branch_i=1 with target 32'h103 while in REQ without ack -> mem_addr_o unchanged until ack, that data dropped, next request to 32'h100, and instr_valid_o=0 in between.
REQ-037 Scenario: branch with coincident ack and pop, FIFO holding 3 entries -> count=0 next cycle and next mem_addr_o = target.
REQ-038 Scenario: fetch_pc=32'hFFFFFFFC with ack -> next mem_addr_o=32'h00000000.
REQ-039 Scenario: rst asserted mid-stream with FIFO at 2 entries -> all outputs at REQ-031 values next cycle and the next request goes to RESET_PC.
